// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: region decode, per-region wait states or external ack, bus-error timeout, fault latch.
// Zero-wait access acks two cycles after AS is sampled low; the CPU is held off by DTACK/BERR until it drops AS.
module m68k_bus_ctrl #(
    parameter int                              C_REGIONS  = 4,
    parameter int                              C_DEC_LO   = 15,
    parameter int                              C_DEC_BITS = 3,
    parameter logic [4*(1<<C_DEC_BITS)-1:0]    C_MAP      = 32'h00003210,
    parameter logic [4*C_REGIONS-1:0]          C_WAIT     = 16'h0000,
    parameter int                              C_TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      as_n,
    input  logic                      uds_n,
    input  logic                      lds_n,
    input  logic                      rw,
    input  logic [22:0]               addr,
    input  logic [16*C_REGIONS-1:0]   rdata,
    input  logic [C_REGIONS-1:0]      ext_ack,
    input  logic                      fault_clr,
    output logic [15:0]               cpu_din,
    output logic                      dtack_n,
    output logic                      berr_n,
    output logic [C_REGIONS-1:0]      sel,
    output logic [C_REGIONS-1:0]      we,
    output logic                      ub,
    output logic                      lb,
    output logic                      fault_valid,
    output logic [22:0]               fault_addr
);

    typedef enum logic [2:0] {SYNC, IDLE, WAIT, XACK, ACK, BERR} state_t;

    localparam logic [7:0] TO_LAST = 8'(C_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [2:0]             region_q, region_d;
    logic [22:0]            addr_q, addr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             timer_q, timer_d;
    logic [C_REGIONS-1:0]   sel_q, sel_d;
    logic                   dtack_q, dtack_d;
    logic                   berr_q, berr_d;
    logic [15:0]            din_q, din_d;
    logic                   fv_q, fv_d;
    logic [22:0]            fa_q, fa_d;

    logic [C_DEC_BITS-1:0]  code;
    logic [3:0]             map_nib;
    logic [3:0]             wait_nib;
    logic                   mapped;
    logic [15:0]            cur_rdata;
    logic                   cur_ack;
    logic                   enter_berr;
    logic [22:0]            berr_addr;
    logic [C_REGIONS-1:0]   dec_sel;

    assign code   = addr[C_DEC_LO +: C_DEC_BITS];
    assign mapped = (int'(map_nib) < C_REGIONS);

    // Decode of the incoming address plus muxing for the latched region
    always_comb begin
        map_nib = 4'hF;
        for (int k = 0; k < (1 << C_DEC_BITS); k++)
            if (code == k[C_DEC_BITS-1:0]) map_nib = C_MAP[4*k +: 4];
        wait_nib  = 4'h0;
        dec_sel   = '0;
        cur_rdata = '0;
        cur_ack   = 1'b0;
        for (int r = 0; r < C_REGIONS; r++) begin
            if (map_nib == r[3:0]) begin
                wait_nib   = C_WAIT[4*r +: 4];
                dec_sel[r] = 1'b1;
            end
            if (region_q == r[2:0]) begin
                cur_rdata = rdata[16*r +: 16];
                cur_ack   = ext_ack[r];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        sel_d      = sel_q;
        dtack_d    = dtack_q;
        berr_d     = berr_q;
        din_d      = din_q;
        fv_d       = fv_q;
        fa_d       = fa_q;
        enter_berr = 1'b0;
        berr_addr  = addr_q;

        case (state_q)
            SYNC: if (as_n) state_d = IDLE;
            IDLE: begin
                if (!as_n) begin
                    region_d = map_nib[2:0];
                    addr_d   = addr;
                    if (!mapped) begin
                        state_d    = BERR;
                        berr_d     = 1'b0;
                        din_d      = 16'hFFFF;
                        enter_berr = 1'b1;
                        berr_addr  = addr;
                    end else begin
                        sel_d = dec_sel;
                        if (wait_nib == 4'hF) begin
                            state_d = XACK;
                            timer_d = 8'd0;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = wait_nib;
                        end
                    end
                end
            end
            WAIT: begin
                if (as_n) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    dtack_d = 1'b0;
                    din_d   = cur_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            XACK: begin
                if (as_n) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end else if (cur_ack) begin
                    state_d = ACK;
                    dtack_d = 1'b0;
                    din_d   = cur_rdata;
                end else if (timer_q == TO_LAST) begin
                    state_d    = BERR;
                    berr_d     = 1'b0;
                    sel_d      = '0;
                    din_d      = 16'hFFFF;
                    enter_berr = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ACK: begin
                din_d = cur_rdata;
                if (as_n) begin
                    state_d = IDLE;
                    dtack_d = 1'b1;
                    sel_d   = '0;
                end
            end
            BERR: begin
                din_d = 16'hFFFF;
                if (as_n) begin
                    state_d = IDLE;
                    berr_d  = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase

        // A fault arriving with fault_clr is treated as the first fault after the clear
        if (fault_clr) fv_d = 1'b0;
        if (enter_berr && (!fv_q || fault_clr)) begin
            fv_d = 1'b1;
            fa_d = berr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SYNC;
            region_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            sel_q    <= '0;
            dtack_q  <= 1'b1;
            berr_q   <= 1'b1;
            din_q    <= '0;
            fv_q     <= 1'b0;
            fa_q     <= '0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            sel_q    <= sel_d;
            dtack_q  <= dtack_d;
            berr_q   <= berr_d;
            din_q    <= din_d;
            fv_q     <= fv_d;
            fa_q     <= fa_d;
        end
    end

    assign sel         = sel_q;
    assign we          = sel_q & {C_REGIONS{~rw & ~(uds_n & lds_n)}};
    assign ub          = ~uds_n & (|sel_q);
    assign lb          = ~lds_n & (|sel_q);
    assign dtack_n     = dtack_q;
    assign berr_n      = berr_q;
    assign cpu_din     = din_q;
    assign fault_valid = fv_q;
    assign fault_addr  = fa_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench: region map codes 0..3 -> r0..r3, 4..6 -> r0, 7 unmapped; waits r2=3, r3=external ack.
module tb_m68k_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        as_n, uds_n, lds_n, rw, fault_clr;
    logic [22:0] addr;
    logic [63:0] rdata;
    logic [3:0]  ext_ack;

    logic [15:0] cpu_din, cpu_din_t;
    logic        dtack_n, berr_n, ub, lb, fault_valid;
    logic        dtack_n_t, berr_n_t, ub_t, lb_t, fault_valid_t;
    logic [3:0]  sel, we, sel_t, we_t;
    logic [22:0] fault_addr, fault_addr_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m68k_bus_ctrl #(
        .C_REGIONS(4), .C_DEC_LO(15), .C_DEC_BITS(3),
        .C_MAP(32'hF0003210), .C_WAIT(16'hF300), .C_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
        .addr(addr), .rdata(rdata), .ext_ack(ext_ack), .fault_clr(fault_clr),
        .cpu_din(cpu_din), .dtack_n(dtack_n), .berr_n(berr_n), .sel(sel), .we(we),
        .ub(ub), .lb(lb), .fault_valid(fault_valid), .fault_addr(fault_addr)
    );

    m68k_bus_ctrl #(
        .C_REGIONS(4), .C_DEC_LO(15), .C_DEC_BITS(3),
        .C_MAP(32'hF0003210), .C_WAIT(16'hF300), .C_TIMEOUT(10)
    ) dut_t (
        .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
        .addr(addr), .rdata(rdata), .ext_ack(ext_ack), .fault_clr(fault_clr),
        .cpu_din(cpu_din_t), .dtack_n(dtack_n_t), .berr_n(berr_n_t), .sel(sel_t), .we(we_t),
        .ub(ub_t), .lb(lb_t), .fault_valid(fault_valid_t), .fault_addr(fault_addr_t)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_bus();
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        rw    = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; as_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
        addr = '0; ext_ack = '0; fault_clr = 1'b0;
        tick(2);
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL rst_dtack: got %b want 1", dtack_n); end
        checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL rst_berr: got %b want 1", berr_n); end
        checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL rst_sel: got %b want 0000", sel); end
        checks++; if (we !== 4'b0000) begin errors++; $display("FAIL rst_we: got %b want 0000", we); end
        checks++; if ({ub, lb} !== 2'b00) begin errors++; $display("FAIL rst_lanes: got %b want 00", {ub, lb}); end
        checks++; if (cpu_din !== 16'h0000) begin errors++; $display("FAIL rst_din: got %h want 0000", cpu_din); end
        checks++; if ({fault_valid, fault_addr} !== 24'h0) begin errors++; $display("FAIL rst_fault: got %b/%h want 0/000000", fault_valid, fault_addr); end
        release_bus();
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_read();
        addr = 23'h00000; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b1; as_n = 1'b0;
        tick(1);
        checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL rd_sel: got %b want 0001", sel); end
        checks++; if ({ub, lb} !== 2'b10) begin errors++; $display("FAIL rd_lanes: got %b want 10", {ub, lb}); end
        checks++; if (we !== 4'b0000) begin errors++; $display("FAIL rd_we: got %b want 0000", we); end
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL rd_dtack_early: got %b want 1", dtack_n); end
        tick(1);
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL rd_dtack: got %b want 0", dtack_n); end
        tick(1);
        checks++; if (cpu_din !== 16'h1234) begin errors++; $display("FAIL rd_din: got %h want 1234", cpu_din); end
        release_bus();
        tick(1);
        checks++; if ({dtack_n, sel} !== 5'b10000) begin errors++; $display("FAIL rd_release: got %b want 10000", {dtack_n, sel}); end
    endtask

    task automatic test_write_wait();
        addr = 23'h10000; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        tick(1);
        checks++; if (we !== 4'b0100) begin errors++; $display("FAIL wr_we: got %b want 0100", we); end
        checks++; if ({ub, lb} !== 2'b11) begin errors++; $display("FAIL wr_lanes: got %b want 11", {ub, lb}); end
        tick(3);
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL wr_dtack_t4: got %b want 1", dtack_n); end
        tick(1);
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL wr_dtack_t5: got %b want 0", dtack_n); end
        checks++; if (we !== 4'b0100) begin errors++; $display("FAIL wr_we_hold: got %b want 0100", we); end
        release_bus();
        tick(1);
        checks++; if ({dtack_n, we} !== 5'b10000) begin errors++; $display("FAIL wr_release: got %b want 10000", {dtack_n, we}); end
    endtask

    task automatic test_ext_ack();
        addr = 23'h18000; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        tick(1);
        checks++; if (sel !== 4'b1000) begin errors++; $display("FAIL xa_sel: got %b want 1000", sel); end
        tick(6);
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL xa_dtack_t7: got %b want 1", dtack_n); end
        ext_ack = 4'b1000;
        tick(1);
        ext_ack = 4'b0000;
        checks++; if ({dtack_n, berr_n} !== 2'b01) begin errors++; $display("FAIL xa_dtack_t8: got %b want 01", {dtack_n, berr_n}); end
        tick(1);
        checks++; if (cpu_din !== 16'hDDDD) begin errors++; $display("FAIL xa_din: got %h want DDDD", cpu_din); end
        release_bus();
        tick(1);
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL xa_release: got %b want 1", dtack_n); end
        // ack arriving in the very cycle the timeout would fire
        as_n = 1'b0; uds_n = 1'b0;
        tick(8);
        checks++; if ({dtack_n, berr_n} !== 2'b11) begin errors++; $display("FAIL xa_edge_pre: got %b want 11", {dtack_n, berr_n}); end
        ext_ack = 4'b1000;
        tick(1);
        ext_ack = 4'b0000;
        checks++; if ({dtack_n, berr_n} !== 2'b01) begin errors++; $display("FAIL xa_edge_ack: got %b want 01", {dtack_n, berr_n}); end
        tick(2);
        checks++; if ({dtack_n, berr_n} !== 2'b01) begin errors++; $display("FAIL xa_edge_hold: got %b want 01", {dtack_n, berr_n}); end
        release_bus();
        tick(1);
    endtask

    task automatic test_back_to_back();
        addr = 23'h08000; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        tick(2);
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL b2b_dtack1: got %b want 0", dtack_n); end
        tick(1);
        checks++; if (cpu_din !== 16'h5678) begin errors++; $display("FAIL b2b_din1: got %h want 5678", cpu_din); end
        release_bus();
        tick(1);
        addr = 23'h00000; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        tick(1);
        checks++; if ({dtack_n, sel} !== 5'b10001) begin errors++; $display("FAIL b2b_sel2: got %b want 10001", {dtack_n, sel}); end
        tick(1);
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL b2b_dtack2: got %b want 0", dtack_n); end
        tick(1);
        checks++; if (cpu_din !== 16'h1234) begin errors++; $display("FAIL b2b_din2: got %h want 1234", cpu_din); end
        release_bus();
        tick(1);
    endtask

    task automatic test_abort();
        addr = 23'h10000; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        tick(2);
        release_bus();
        tick(1);
        checks++; if ({sel, we} !== 8'h00) begin errors++; $display("FAIL abort_sel: got %b want 00000000", {sel, we}); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({dtack_n, berr_n} !== 2'b11) begin errors++; $display("FAIL abort_quiet%0d: got %b want 11", i, {dtack_n, berr_n}); end
            tick(1);
        end
    endtask

    task automatic test_fault();
        addr = 23'h3C000; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        tick(1);
        checks++; if ({berr_n, dtack_n, sel} !== 6'b010000) begin errors++; $display("FAIL flt_berr: got %b want 010000", {berr_n, dtack_n, sel}); end
        checks++; if ({fault_valid, fault_addr} !== {1'b1, 23'h3C000}) begin errors++; $display("FAIL flt_latch: got %b/%h want 1/03c000", fault_valid, fault_addr); end
        checks++; if (cpu_din !== 16'hFFFF) begin errors++; $display("FAIL flt_din: got %h want FFFF", cpu_din); end
        release_bus();
        tick(1);
        checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL flt_release: got %b want 1", berr_n); end
        addr = 23'h3C002; as_n = 1'b0;
        tick(1);
        checks++; if ({berr_n, fault_addr} !== {1'b0, 23'h3C000}) begin errors++; $display("FAIL flt_second: got %b/%h want 0/03c000", berr_n, fault_addr); end
        release_bus();
        tick(1);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        checks++; if (fault_valid !== 1'b0) begin errors++; $display("FAIL flt_clr: got %b want 0", fault_valid); end
        addr = 23'h3C004; as_n = 1'b0; fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        checks++; if ({fault_valid, fault_addr} !== {1'b1, 23'h3C004}) begin errors++; $display("FAIL flt_clr_race: got %b/%h want 1/03c004", fault_valid, fault_addr); end
        release_bus();
        tick(1);
    endtask

    task automatic test_reset_in_wait();
        addr = 23'h10000; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++; if ({dtack_n, berr_n, sel, ub, lb} !== 8'b11000000) begin errors++; $display("FAIL rw_idle: got %b want 11000000", {dtack_n, berr_n, sel, ub, lb}); end
        checks++; if ({fault_valid, cpu_din} !== 17'h0) begin errors++; $display("FAIL rw_regs: got %b/%h want 0/0000", fault_valid, cpu_din); end
        tick(6);
        checks++; if ({dtack_n, sel} !== 5'b10000) begin errors++; $display("FAIL rw_no_decode: got %b want 10000", {dtack_n, sel}); end
        as_n = 1'b1;
        tick(1);
        addr = 23'h00000; as_n = 1'b0;
        tick(1);
        checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL rw_resume_sel: got %b want 0001", sel); end
        tick(1);
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL rw_resume_dtack: got %b want 0", dtack_n); end
        release_bus();
        tick(1);
    endtask

    task automatic test_timeout();
        addr = 23'h18000; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        tick(10);
        checks++; if (berr_n_t !== 1'b1) begin errors++; $display("FAIL to_berr_t10: got %b want 1", berr_n_t); end
        tick(1);
        checks++; if ({berr_n_t, dtack_n_t} !== 2'b01) begin errors++; $display("FAIL to_berr_t11: got %b want 01", {berr_n_t, dtack_n_t}); end
        checks++; if ({fault_valid_t, fault_addr_t} !== {1'b1, 23'h18000}) begin errors++; $display("FAIL to_fault: got %b/%h want 1/018000", fault_valid_t, fault_addr_t); end
        tick(2);
        checks++; if (berr_n_t !== 1'b0) begin errors++; $display("FAIL to_hold: got %b want 0", berr_n_t); end
        release_bus();
        tick(1);
        checks++; if ({berr_n_t, dtack_n_t} !== 2'b11) begin errors++; $display("FAIL to_release: got %b want 11", {berr_n_t, dtack_n_t}); end
    endtask

    initial begin
        rdata = {16'hDDDD, 16'hCCCC, 16'h5678, 16'h1234};
        test_reset();
        test_read();
        test_write_wait();
        test_ext_ack();
        test_back_to_back();
        test_abort();
        test_fault();
        test_reset_in_wait();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
